// File: rtl/uart_rx_core.sv
// UART receiver: 16x oversampled 8N1 deframer with a one-cycle done strobe.
// Define UART_RX_PARITY_EN to add an even-parity bit before the stop bit (8E1).
module uart_rx_core #(
  parameter int CLK_FREQ  = 100_000_000,
  parameter int BAUD_RATE = 9600,
  parameter int DATA_BITS = 8
) (
  input  logic                 PCLK,
  input  logic                 PRESET,
  input  logic                 rx_en,
  input  logic                 rx_rst,
  input  logic                 rx_serial,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_done,
  output logic                 rx_busy,
  output logic                 rx_err,
  output logic                 parity_err
);

  localparam int DIV = CLK_FREQ / (BAUD_RATE * 16);
  localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BW  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP,
    BRK
  } state_t;

  state_t               state;
  state_t               state_n;
  logic                 srst;
  logic                 rs1;
  logic                 rs;
  logic [DW-1:0]        div_cnt;
  logic [3:0]           sample_cnt;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 tick;
  logic                 mid;
  logic                 last_bit;

  assign srst     = PRESET | rx_rst;
  assign tick     = (div_cnt == DW'(DIV - 1));
  assign mid      = tick &&
                    (sample_cnt == ((state == START) ? 4'd7 : 4'd15));
  assign last_bit = (bit_cnt == BW'(DATA_BITS - 1));
  assign rx_busy  = (state != IDLE);

  // Two-flop synchronizer for the asynchronous line, idles high.
  always_ff @(posedge PCLK) begin
    if (srst) begin
      rs1 <= 1'b1;
      rs  <= 1'b1;
    end else begin
      rs1 <= rx_serial;
      rs  <= rs1;
    end
  end

  // State register.
  always_ff @(posedge PCLK) begin
    if (srst) state <= IDLE;
    else      state <= state_n;
  end

  // Next-state logic; dropping rx_en aborts any frame in flight.
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:   if (rx_en && !rs) state_n = START;
      START:  if (mid) state_n = rs ? IDLE : DATA;
`ifdef UART_RX_PARITY_EN
      DATA:   if (mid && last_bit) state_n = PARITY;
      PARITY: if (mid) state_n = STOP;
`else
      DATA:   if (mid && last_bit) state_n = STOP;
`endif
      STOP:   if (mid) state_n = rs ? IDLE : BRK;
      BRK:    if (rs) state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (!rx_en && state != IDLE) state_n = IDLE;
  end

  // Baud divider, oversample and bit counters; held at zero in IDLE.
  always_ff @(posedge PCLK) begin
    if (srst || state == IDLE || state_n == IDLE) begin
      div_cnt    <= '0;
      sample_cnt <= '0;
      bit_cnt    <= '0;
    end else begin
      div_cnt <= tick ? '0 : div_cnt + 1'b1;
      if (tick) begin
        if (state == START && mid) sample_cnt <= 4'd0;
        else                       sample_cnt <= sample_cnt + 4'd1;
      end
      if (state == DATA && mid) begin
        bit_cnt <= last_bit ? '0 : bit_cnt + 1'b1;
      end
    end
  end

  // Shift register, output byte, done strobe and framing error.
  always_ff @(posedge PCLK) begin
    if (srst) begin
      shreg   <= '0;
      rx_data <= '0;
      rx_done <= 1'b0;
      rx_err  <= 1'b0;
    end else begin
      rx_done <= 1'b0;
      if (rx_en && mid) begin
        case (state)
          DATA: shreg[bit_cnt] <= rs;
          STOP: begin
            if (rs) begin
              rx_data <= shreg;
              rx_done <= 1'b1;
            end else begin
              rx_err <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  // Even parity check on the received payload; sticky until reset.
  always_ff @(posedge PCLK) begin
    if (srst) begin
      parity_err <= 1'b0;
    end else if (rx_en && mid && state == PARITY) begin
      if (rs != ^shreg) parity_err <= 1'b1;
    end
  end
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed bench for uart_rx_core at a fast baud (DIV=4, 64 clocks/bit).
// Define UART_RX_PARITY_EN to exercise the 8E1 build.
module tb_uart_rx_core;
  localparam int CLK_FREQ = 100_000_000;
  localparam int BAUD     = 1_562_500;
  localparam int BIT      = 64;

  logic       PCLK;
  logic       PRESET;
  logic       rx_en;
  logic       rx_rst;
  logic       rx_serial;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       rx_busy;
  logic       rx_err;
  logic       parity_err;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int busy_cnt = 0;
  int dbl_cnt  = 0;
  int stop_cyc = 0;
  logic prev_done = 1'b0;
  logic finished  = 1'b0;

  int d0;
  int b0;
  int dly;

  uart_rx_core #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD_RATE(BAUD),
    .DATA_BITS(8)
  ) dut (
    .PCLK      (PCLK),
    .PRESET    (PRESET),
    .rx_en     (rx_en),
    .rx_rst    (rx_rst),
    .rx_serial (rx_serial),
    .rx_data   (rx_data),
    .rx_done   (rx_done),
    .rx_busy   (rx_busy),
    .rx_err    (rx_err),
    .parity_err(parity_err)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  always @(posedge PCLK) cyc++;

  always @(negedge PCLK) begin
    if (rx_done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (rx_done && prev_done) dbl_cnt++;
    prev_done = rx_done;
    if (rx_busy) busy_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    rx_serial = 1'b1;
    repeat (n) @(negedge PCLK);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_b,
                            input logic par_b, input int drop_at,
                            input int rst_at);
    logic [10:0] fr;
    int nb;
    fr = '1;
    fr[0] = 1'b0;
    fr[8:1] = d;
`ifdef UART_RX_PARITY_EN
    fr[9]  = par_b;
    fr[10] = stop_b;
    nb = 11;
`else
    fr[9] = stop_b;
    nb = 10;
`endif
    for (int i = 0; i < nb; i++) begin
      rx_serial = fr[i];
      if (i == nb - 1) stop_cyc = cyc;
      if (i == drop_at) rx_en = 1'b0;
      for (int c = 0; c < BIT; c++) begin
        @(negedge PCLK);
        rx_rst = (i == rst_at && c == 1);
      end
    end
    rx_rst = 1'b0;
  endtask

  initial begin
    #5ms;
    chk("timeout", finished, 1'b1);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    PRESET    = 1'b1;
    rx_en     = 1'b0;
    rx_rst    = 1'b0;
    rx_serial = 1'b1;
    repeat (3) @(negedge PCLK);
    PRESET = 1'b0;
    @(negedge PCLK);
    chk("rst_data", rx_data, 8'h00);
    chk("rst_done", rx_done, 1'b0);
    chk("rst_busy", rx_busy, 1'b0);
    chk("rst_err", rx_err, 1'b0);
    chk("rst_perr", parity_err, 1'b0);

    rx_en = 1'b1;
    idle(16);
    d0 = done_cnt;
    send_frame(8'hA5, 1'b1, 1'b0, -1, -1);
    idle(16);
    dly = done_cyc - stop_cyc;
    chk("a5_data", rx_data, 8'hA5);
    chk("a5_done", done_cnt, d0 + 1);
    chk("a5_lat", (dly >= 31 && dly <= 40), 1'b1);
    chk("a5_err", rx_err, 1'b0);
    chk("a5_busy", rx_busy, 1'b0);

    d0 = done_cnt;
    send_frame(8'h3C, 1'b0, 1'b0, -1, -1);
    rx_serial = 1'b0;
    repeat (2 * BIT) @(negedge PCLK);
    chk("fe_err", rx_err, 1'b1);
    chk("fe_data", rx_data, 8'hA5);
    chk("fe_done", done_cnt, d0);
    chk("fe_brk_busy", rx_busy, 1'b1);
    idle(16);
    chk("fe_rel_busy", rx_busy, 1'b0);
    send_frame(8'h5A, 1'b1, 1'b0, -1, -1);
    idle(16);
    chk("5a_data", rx_data, 8'h5A);
    chk("5a_err", rx_err, 1'b1);
    chk("5a_done", done_cnt, d0 + 1);

    d0 = done_cnt;
    b0 = busy_cnt;
    rx_serial = 1'b0;
    repeat (15) @(negedge PCLK);
    idle(2 * BIT);
    chk("gl_busy_seen", (busy_cnt > b0), 1'b1);
    chk("gl_busy", rx_busy, 1'b0);
    chk("gl_done", done_cnt, d0);
    chk("gl_perr", parity_err, 1'b0);

    rx_en = 1'b0;
    b0 = busy_cnt;
    send_frame(8'hFF, 1'b1, 1'b0, -1, -1);
    idle(16);
    chk("dis_busy", busy_cnt, b0);
    chk("dis_done", done_cnt, d0);

    rx_en = 1'b1;
    idle(4);
    send_frame(8'h33, 1'b1, 1'b0, 5, -1);
    idle(16);
    chk("ab_done", done_cnt, d0);
    chk("ab_busy", rx_busy, 1'b0);
    chk("ab_data", rx_data, 8'h5A);

    rx_en = 1'b1;
    idle(4);
    send_frame(8'hE3, 1'b1, 1'b1, -1, 6);
    idle(16);
    chk("sr_data", rx_data, 8'h00);
    chk("sr_err", rx_err, 1'b0);
    chk("sr_perr", parity_err, 1'b0);
    chk("sr_busy", rx_busy, 1'b0);
    chk("sr_done", done_cnt, d0);

    d0 = done_cnt;
    send_frame(8'h81, 1'b1, 1'b0, -1, -1);
    idle(16);
    chk("p0_data", rx_data, 8'h81);
    chk("p0_perr", parity_err, 1'b0);
    chk("p0_done", done_cnt, d0 + 1);
`ifdef UART_RX_PARITY_EN
    send_frame(8'h7E, 1'b1, 1'b1, -1, -1);
    idle(16);
    chk("p1_data", rx_data, 8'h7E);
    chk("p1_perr", parity_err, 1'b1);
    chk("p1_done", done_cnt, d0 + 2);
`endif

    chk("no_double", dbl_cnt, 0);

    finished = 1'b1;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
